// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared mode encodings, default geometry and default bitmap for the text overlay
package text_pkg;

  // Display modes: bit 0 enables scrolling, bit 1 enables blinking.
  localparam logic [1:0] MODE_STATIC       = 2'b00;
  localparam logic [1:0] MODE_SCROLL       = 2'b01;
  localparam logic [1:0] MODE_BLINK        = 2'b10;
  localparam logic [1:0] MODE_SCROLL_BLINK = 2'b11;

  // Default cell geometry of the demo banner.
  localparam int DEF_BMP_W      = 60;
  localparam int DEF_BMP_H      = 10;
  localparam int DEF_CELL_SHIFT = 3;
  localparam int DEF_ORIGIN_X   = 11;
  localparam int DEF_ORIGIN_Y   = 38;
  localparam int DEF_WINDOW_W   = 60;

  // Default banner, row 0 in the least significant word, bit 0 = leftmost cell.
  localparam logic [DEF_BMP_H*DEF_BMP_W-1:0] DEF_BITMAP = {
    60'h1000000000000F8,
    60'hFFFF0000FFFF000,
    60'h0123456789ABCDE,
    60'hC3C3C3C3C3C3C3C,
    60'h800000000000001,
    60'h555555555555555,
    60'hAAAAAAAAAAAAAAA,
    60'h0F0F0F0F0F0F0F0,
    60'hFEDCBA987654321,
    60'h123456789ABCDEF
  };

endpackage

// File: rtl/text_bitmap_rom.sv
// rtl/text_bitmap_rom.sv - combinational 1-bit-per-cell bitmap lookup
module text_bitmap_rom
  import text_pkg::*;
#(
  parameter int                       BMP_W  = DEF_BMP_W,
  parameter int                       BMP_H  = DEF_BMP_H,
  parameter logic [BMP_H*BMP_W-1:0]   BITMAP = DEF_BITMAP
) (
  input  logic [5:0] i_row,
  input  logic [6:0] i_col,
  output logic       o_bit
);

  logic [BMP_W-1:0] w_row;

  // Row select; rows at or beyond BMP_H read as blank.
  always_comb begin
    w_row = '0;
    for (int r = 0; r < BMP_H; r++) begin
      if (i_row == r[5:0]) begin
        w_row = BITMAP[r*BMP_W +: BMP_W];
      end
    end
  end

  // Column select; columns at or beyond BMP_W read as blank.
  always_comb begin
    o_bit = 1'b0;
    for (int c = 0; c < BMP_W; c++) begin
      if (i_col == c[6:0]) begin
        o_bit = w_row[c];
      end
    end
  end

endmodule

// File: rtl/text_scroller.sv
// rtl/text_scroller.sv - frame-synchronous scrolling/blinking text overlay generator
module text_scroller
  import text_pkg::*;
#(
  parameter int                     BMP_W        = DEF_BMP_W,
  parameter int                     BMP_H        = DEF_BMP_H,
  parameter int                     CELL_SHIFT   = DEF_CELL_SHIFT,
  parameter int                     ORIGIN_X     = DEF_ORIGIN_X,
  parameter int                     ORIGIN_Y     = DEF_ORIGIN_Y,
  parameter int                     WINDOW_W     = DEF_WINDOW_W,
  parameter int                     SCROLL_DIV   = 4,
  parameter int                     BLINK_FRAMES = 32,
  parameter logic [BMP_H*BMP_W-1:0] BITMAP       = DEF_BITMAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       overlay_active
);

  localparam logic [6:0]  WIN_W      = 7'(WINDOW_W);
  localparam logic [5:0]  ROWS       = 6'(BMP_H);
  localparam logic [7:0]  BMP_W8     = 8'(BMP_W);
  localparam logic [6:0]  COL_LAST   = 7'(BMP_W - 1);
  localparam logic [15:0] DIV_LAST   = 16'(SCROLL_DIV - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic [1:0]  r_mode_q;
  logic [6:0]  r_scroll_off;
  logic [15:0] r_div_cnt;
  logic [15:0] r_blink_cnt;
  logic        r_blink_ph;
  logic        r_overlay;

  logic [6:0]  w_cx;
  logic [5:0]  w_cy;
  logic        w_in_window;
  logic [7:0]  w_sum;
  logic [6:0]  w_bc;
  logic        w_pix;
  logic        w_blank;

  // Reset synchroniser: assertion passes straight through, release lines up with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Cell coordinates relative to the window origin; negatives wrap to large values.
  assign w_cx        = 7'((x >> CELL_SHIFT) - 10'(ORIGIN_X));
  assign w_cy        = 6'((y >> CELL_SHIFT) - 10'(ORIGIN_Y));
  assign w_in_window = (w_cx < WIN_W) && (w_cy < ROWS);

  // Both terms are below BMP_W, so one conditional subtract completes the wrap.
  assign w_sum = {1'b0, w_cx} + {1'b0, r_scroll_off};
  assign w_bc  = (w_sum >= BMP_W8) ? 7'(w_sum - BMP_W8) : w_sum[6:0];

  text_bitmap_rom #(
    .BMP_W  (BMP_W),
    .BMP_H  (BMP_H),
    .BITMAP (BITMAP)
  ) u_rom (
    .i_row (w_cy),
    .i_col (w_bc),
    .o_bit (w_pix)
  );

  assign w_blank = r_mode_q[1] & r_blink_ph;

  // Frame counters and mode shadow; every tick acts on the mode held before it.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mode_q     <= MODE_STATIC;
      r_scroll_off <= '0;
      r_div_cnt    <= '0;
      r_blink_cnt  <= '0;
      r_blink_ph   <= 1'b0;
    end else if (frame_tick) begin
      r_mode_q <= mode;
      if (r_mode_q[0]) begin
        if (r_div_cnt == DIV_LAST) begin
          r_div_cnt    <= '0;
          r_scroll_off <= (r_scroll_off == COL_LAST) ? 7'd0 : r_scroll_off + 7'd1;
        end else begin
          r_div_cnt <= r_div_cnt + 16'd1;
        end
      end else begin
        r_div_cnt    <= '0;
        r_scroll_off <= '0;
      end
      if (r_mode_q[1]) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_blink_cnt <= r_blink_cnt + 16'd1;
        end
      end else begin
        r_blink_cnt <= '0;
        r_blink_ph  <= 1'b0;
      end
    end
  end

  // Registered overlay flag, one cycle behind the beam position.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_overlay <= 1'b0;
    end else begin
      r_overlay <= enable & w_in_window & w_pix & ~w_blank;
    end
  end

  assign overlay_active = r_overlay;

endmodule

// File: tb/tb_text_scroller.sv
// tb/tb_text_scroller.sv - directed self-checking bench for text_scroller
module tb_text_scroller;
  import text_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] mode = MODE_STATIC;
  logic       overlay_active;

  int checks = 0;
  int errors = 0;

  logic [599:0] bmp;

  always #5 clk = ~clk;

  text_scroller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .x              (x),
    .y              (y),
    .frame_tick     (frame_tick),
    .enable         (enable),
    .mode           (mode),
    .overlay_active (overlay_active)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model(input int px, input int py, input int soff, input bit blank);
    int cx;
    int cy;
    logic [599:0] t;
    cx = ((px >> 3) - 11) & 127;
    cy = ((py >> 3) - 38) & 63;
    if (blank || cx >= 60 || cy >= 10) return 1'b0;
    t = bmp >> (cy * 60 + ((cx + soff) % 60));
    return t[0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic probe(input string tag, input int px, input int py, input int soff, input bit blank);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    @(negedge clk);
    check(tag, overlay_active, model(px, py, soff, blank));
  endtask

  // New position every cycle; each sample checks the position from the previous cycle.
  task automatic sweep(input string tag, input int soff, input bit blank);
    logic e;
    bit   have;
    int   px;
    int   py;
    have = 1'b0;
    e    = 1'b0;
    for (int cy = -1; cy <= 10; cy++) begin
      for (int cx = -1; cx <= 60; cx++) begin
        px = (11 + cx) * 8 + (cx & 7);
        py = (38 + cy) * 8 + (cy & 7);
        @(negedge clk);
        if (have) check(tag, overlay_active, e);
        x = 10'(px);
        y = 10'(py);
        e = model(px, py, soff, blank);
        have = 1'b1;
      end
    end
    @(negedge clk);
    check(tag, overlay_active, e);
  endtask

  initial begin
    bmp = {60'h1000000000000F8, 60'hFFFF0000FFFF000, 60'h0123456789ABCDE,
           60'hC3C3C3C3C3C3C3C, 60'h800000000000001, 60'h555555555555555,
           60'hAAAAAAAAAAAAAAA, 60'h0F0F0F0F0F0F0F0, 60'hFEDCBA987654321,
           60'h123456789ABCDEF};

    // Reset with the beam on a lit cell.
    x = 10'd88;
    y = 10'd304;
    repeat (3) @(negedge clk);
    check("reset_out", overlay_active, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Static lookup and out-of-range edges.
    sweep("static", 0, 1'b0);
    probe("left_edge", 80, 310, 0, 1'b0);
    probe("top_edge", 100, 296, 0, 1'b0);
    probe("origin_wrap", 0, 0, 0, 1'b0);
    probe("far_corner", 1023, 1023, 0, 1'b0);
    probe("lit_cell", 88, 304, 0, 1'b0);

    // Scrolling: one tick loads the mode, then SCROLL_DIV ticks per step.
    mode = MODE_SCROLL;
    tick(5);
    sweep("scroll1", 1, 1'b0);
    tick(58 * 4);
    sweep("scroll59", 59, 1'b0);
    tick(3);
    probe("div_hold", 88, 304, 59, 1'b0);
    tick(1);
    sweep("scroll_wrap", 0, 1'b0);

    // Mid-frame mode change takes effect only through ticks.
    tick(4);
    @(negedge clk);
    mode = MODE_STATIC;
    sweep("mode_hold", 1, 1'b0);
    tick(1);
    sweep("mode_load", 1, 1'b0);
    tick(1);
    sweep("mode_clear", 0, 1'b0);

    // Blink: load tick + 32 counting ticks blanks, 32 more restore.
    mode = MODE_BLINK;
    tick(33);
    sweep("blink_off", 0, 1'b1);
    tick(31);
    probe("blink_hold", 88, 304, 0, 1'b1);
    tick(1);
    sweep("blink_on", 0, 1'b0);

    // Enable gating while counters keep running.
    mode = MODE_SCROLL;
    tick(2);
    probe("en_lit", 88, 304, 0, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("en_off", overlay_active, 1'b0);
    tick(3);
    check("en_off_ticks", overlay_active, 1'b0);
    enable = 1'b1;
    sweep("en_resume", 1, 1'b0);

    // Asynchronous reset mid-line, scroll restarts at zero.
    probe("pre_rst", 88, 304, 1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", overlay_active, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sweep("after_rst", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
